// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  // States in which the stream port is open.
  function automatic logic state_accepts(state_e s);
    return (s == StLenHi) || (s == StLenLo) || (s == StData) || (s == StCheck);
  endfunction

  // States from which a new load may be started.
  function automatic logic state_startable(state_e s);
    return (s == StIdle) || (s == StDone) || (s == StError);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes MSB-first into 32-bit words; emits a one-cycle valid.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic [1:0]        byte_idx_i,
  input  logic              accept_i,
  input  logic              clear_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int unsigned ShiftW = WORD_W - BYTE_W;

  logic [ShiftW-1:0] shift_q;
  logic [WORD_W-1:0] word_q;
  logic              word_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear_i) begin
        shift_q <= '0;
      end else if (accept_i) begin
        if (byte_idx_i == 2'd3) begin
          word_q       <= {shift_q, byte_i};
          word_valid_q <= 1'b1;
          shift_q      <= '0;
        end else begin
          shift_q <= {shift_q[ShiftW-BYTE_W-1:0], byte_i};
        end
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, big-endian words to instruction memory, XOR checksum,
// holds the core in reset until a load completes with a matching checksum.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [BYTE_W-1:0] byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [WORD_W-1:0] imem_addr_o,
  output logic [WORD_W-1:0] imem_wdata_o,
  output logic [LEN_W-1:0]  words_loaded_o,
  output logic              done_o,
  output logic              error_o,
  output logic              cpu_hold_o
);

  localparam logic [31:0] MaxWordsW = 32'(MAX_WORDS);

  state_e             state_q;
  logic [BYTE_W-1:0]  len_hi_q;
  logic [LEN_W-1:0]   len_q;
  logic [BYTE_W-1:0]  csum_q;
  logic [1:0]         byte_idx_q;
  logic [WORD_W-1:0]  next_addr_q;
  logic [WORD_W-1:0]  imem_addr_q;
  logic [LEN_W-1:0]   words_loaded_q;
  logic               done_q;
  logic               error_q;
  logic               cpu_hold_q;

  logic               accept;
  logic               start_fire;
  logic               data_accept;
  logic [LEN_W-1:0]   len_new;

  assign byte_ready_o = state_accepts(state_q);
  assign accept       = byte_valid_i & byte_ready_o;
  assign start_fire   = start_i & state_startable(state_q);
  assign data_accept  = accept & (state_q == StData);
  assign len_new      = {len_hi_q, byte_in_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      len_hi_q       <= '0;
      len_q          <= '0;
      csum_q         <= '0;
      byte_idx_q     <= '0;
      next_addr_q    <= BASE_ADDR;
      imem_addr_q    <= BASE_ADDR;
      words_loaded_q <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      cpu_hold_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start_i) begin
            state_q        <= StLenHi;
            csum_q         <= '0;
            byte_idx_q     <= '0;
            next_addr_q    <= BASE_ADDR;
            imem_addr_q    <= BASE_ADDR;
            words_loaded_q <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_hold_q     <= 1'b1;
          end
        end
        StLenHi: begin
          if (accept) begin
            len_hi_q <= byte_in_i;
            csum_q   <= csum_q ^ byte_in_i;
            state_q  <= StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_q  <= len_new;
            csum_q <= csum_q ^ byte_in_i;
            if (len_new == '0) begin
              state_q <= StCheck;
            end else if (32'(len_new) > MaxWordsW) begin
              state_q <= StError;
              error_q <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            csum_q     <= csum_q ^ byte_in_i;
            byte_idx_q <= byte_idx_q + 2'd1;
            // Address and count are registered alongside the assembler's word strobe.
            if (byte_idx_q == 2'd3) begin
              imem_addr_q    <= next_addr_q;
              next_addr_q    <= next_addr_q + 32'd4;
              words_loaded_q <= words_loaded_q + 16'd1;
              if (words_loaded_q == len_q - 16'd1) begin
                state_q <= StCheck;
              end
            end
          end
        end
        StCheck: begin
          if (accept) begin
            if (byte_in_i == csum_q) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  word_assembler u_word_assembler (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_i       (byte_in_i),
    .byte_idx_i   (byte_idx_q),
    .accept_i     (data_accept),
    .clear_i      (start_fire),
    .word_valid_o (imem_we_o),
    .word_o       (imem_wdata_o)
  );

  assign imem_addr_o    = imem_addr_q;
  assign words_loaded_o = words_loaded_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign cpu_hold_o     = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized loads against a stream-level reference model.
module tb_imem_loader;

  localparam logic [31:0] Base = 32'h0000_0000;
  localparam int          Max  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] words_loaded;
  logic        done;
  logic        error;
  logic        cpu_hold;

  imem_loader #(
    .BASE_ADDR (Base),
    .MAX_WORDS (Max)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .byte_in_i      (byte_in),
    .byte_valid_i   (byte_valid),
    .byte_ready_o   (byte_ready),
    .imem_we_o      (imem_we),
    .imem_addr_o    (imem_addr),
    .imem_wdata_o   (imem_wdata),
    .words_loaded_o (words_loaded),
    .done_o         (done),
    .error_o        (error),
    .cpu_hold_o     (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] wl;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [7:0]  stream[$];
  logic [31:0] wq[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected accept", name);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", imem_addr, 32'hxxxx_xxxx);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", imem_addr, mon_e.addr);
        check("wr_data", imem_wdata, mon_e.data);
        check("wr_count", {16'd0, words_loaded}, {16'd0, mon_e.wl});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive stream[] with optional random bubbles; each accept is decided before the edge.
  task automatic send_stream(input bit throttle);
    for (int i = 0; i < stream.size(); i++) begin
      bit acc = 1'b0;
      int waits = 0;
      while (!acc) begin
        if (throttle && $urandom_range(0, 2) == 0) begin
          byte_valid = 1'b0;
          byte_in    = 8'($urandom);
        end else begin
          byte_valid = 1'b1;
          byte_in    = stream[i];
        end
        if (throttle && i >= 2 && i < stream.size() - 1)
          check("ready_in_data", {31'd0, byte_ready}, 32'd1);
        acc = byte_valid && byte_ready;
        tick();
        waits++;
        if (!acc && waits > 50) begin
          fail_now("byte_accept");
          byte_valid = 1'b0;
          return;
        end
      end
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  // Builds the stream for wq[] (or a bare header when len exceeds Max) and checks the outcome.
  task automatic run_load(input int len, input bit bad_csum, input bit throttle);
    logic [7:0] cs;
    bit         ok;
    stream.delete();
    stream.push_back(8'(len >> 8));
    stream.push_back(8'(len));
    if (len <= Max) begin
      for (int k = 0; k < len; k++) begin
        for (int b = 3; b >= 0; b--) stream.push_back(8'(wq[k] >> (8 * b)));
        exp_q.push_back('{addr: Base + 32'(4 * k), data: wq[k], wl: 16'(k + 1)});
      end
      cs = 8'h00;
      foreach (stream[i]) cs = cs ^ stream[i];
      stream.push_back(bad_csum ? (cs ^ 8'h01) : cs);
    end
    ok = (len <= Max) && !bad_csum;
    do_start();
    check("start_done_clr", {31'd0, done}, 32'd0);
    check("start_err_clr", {31'd0, error}, 32'd0);
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
    check("start_wl_clr", {16'd0, words_loaded}, 32'd0);
    check("start_ready", {31'd0, byte_ready}, 32'd1);
    send_stream(throttle);
    check("end_done", {31'd0, done}, {31'd0, ok});
    check("end_error", {31'd0, error}, {31'd0, !ok});
    check("end_hold", {31'd0, cpu_hold}, {31'd0, !ok});
    check("end_ready", {31'd0, byte_ready}, 32'd0);
    check("end_wl", {16'd0, words_loaded}, (len <= Max) ? 32'(len) : 32'd0);
    repeat (3) tick();
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    check("done_held", {31'd0, done}, {31'd0, ok});
    exp_q.delete();
  endtask

  task automatic load_normal();
    wq.delete();
    wq.push_back(32'h2008_0005);
    wq.push_back(32'hAC09_0000);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #1;
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_addr", imem_addr, Base);
    check("rst_wl", {16'd0, words_loaded}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    load_normal();
    run_load(2, 1'b0, 1'b0);
    load_normal();
    run_load(2, 1'b1, 1'b0);
    run_load(257, 1'b0, 1'b0);
    wq.delete();
    run_load(0, 1'b0, 1'b0);
    load_normal();
    run_load(2, 1'b0, 1'b1);

    // Reset after two bytes of word 1: only word 0 may be written.
    load_normal();
    exp_q.push_back('{addr: Base, data: 32'h2008_0005, wl: 16'd1});
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h02);
    for (int b = 3; b >= 0; b--) stream.push_back(8'(wq[0] >> (8 * b)));
    stream.push_back(8'hAC);
    stream.push_back(8'h09);
    do_start();
    send_stream(1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_we", {31'd0, imem_we}, 32'd0);
    check("mid_rst_addr", imem_addr, Base);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_wl", {16'd0, words_loaded}, 32'd0);
    check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("mid_rst_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    run_load(2, 1'b0, 1'b0);

    // Reload straight from DONE.
    wq.delete();
    wq.push_back(32'hFFFF_FFFF);
    run_load(1, 1'b0, 1'b0);

    // Randomized loads, including the largest accepted length.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 8);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back($urandom);
      run_load(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
    end
    wq.delete();
    for (int k = 0; k < Max; k++) wq.push_back($urandom);
    run_load(Max, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
